// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative FFT core.
// Holds the FSM state type, bit-reversal and twiddle ROM generators.
package fft_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        UNLOAD
    } state_t;

    localparam int  DEF_SIZE = 8;
    localparam real PI       = 3.14159265358979323846;

    // Reverse the low l bits of idx.
    function automatic int bitrev(int idx, int l);
        int r;
        r = 0;
        for (int i = 0; i < l; i++) begin
            if (idx[i]) r[l-1-i] = 1'b1;
        end
        return r;
    endfunction

    // Quantise v to Q1.(tw_bits-1); +1.0 saturates to the largest code.
    function automatic int tw_quant(real v, int tw_bits);
        int fs;
        int r;
        fs = 1 << (tw_bits - 1);
        r  = int'(v * real'(fs));
        if (r > fs - 1) r = fs - 1;
        if (r < -fs)    r = -fs;
        return r;
    endfunction

    function automatic int twiddle_cos(int k, int n, int tw_bits);
        return tw_quant($cos(2.0 * PI * real'(k) / real'(n)), tw_bits);
    endfunction

    function automatic int twiddle_sin(int k, int n, int tw_bits);
        return tw_quant($sin(2.0 * PI * real'(k) / real'(n)), tw_bits);
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: x = a + W*b, y = a - W*b.
// Ports: a_*_i/b_*_i operands, w_*_i twiddle, x_*_o/y_*_o results.
module fft_butterfly #(
    parameter int OUT_BITS = 24,
    parameter int TW_BITS  = 16,
    parameter int SCALE    = 0
) (
    input  logic signed [OUT_BITS-1:0] a_re_i,
    input  logic signed [OUT_BITS-1:0] a_im_i,
    input  logic signed [OUT_BITS-1:0] b_re_i,
    input  logic signed [OUT_BITS-1:0] b_im_i,
    input  logic signed [TW_BITS-1:0]  w_re_i,
    input  logic signed [TW_BITS-1:0]  w_im_i,
    output logic signed [OUT_BITS-1:0] x_re_o,
    output logic signed [OUT_BITS-1:0] x_im_o,
    output logic signed [OUT_BITS-1:0] y_re_o,
    output logic signed [OUT_BITS-1:0] y_im_o
);

    localparam int PW  = OUT_BITS + TW_BITS + 1;
    localparam int TRW = OUT_BITS + 2;
    localparam int SW  = OUT_BITS + 3;
    localparam logic signed [PW-1:0] RND = PW'(2 ** (TW_BITS - 2));

    logic signed [PW-1:0]  pr, pi;
    logic signed [TRW-1:0] tr, ti;
    logic signed [SW-1:0]  sr, si, dr, di;

    always_comb begin
        pr = PW'(b_re_i) * PW'(w_re_i) - PW'(b_im_i) * PW'(w_im_i);
        pi = PW'(b_re_i) * PW'(w_im_i) + PW'(b_im_i) * PW'(w_re_i);
        tr = TRW'((pr + RND) >>> (TW_BITS - 1));
        ti = TRW'((pi + RND) >>> (TW_BITS - 1));
        sr = SW'(a_re_i) + SW'(tr);
        si = SW'(a_im_i) + SW'(ti);
        dr = SW'(a_re_i) - SW'(tr);
        di = SW'(a_im_i) - SW'(ti);
        // Scale before truncation so the extra headroom bit is kept.
        x_re_o = OUT_BITS'((SCALE != 0) ? (sr >>> 1) : sr);
        x_im_o = OUT_BITS'((SCALE != 0) ? (si >>> 1) : si);
        y_re_o = OUT_BITS'((SCALE != 0) ? (dr >>> 1) : dr);
        y_im_o = OUT_BITS'((SCALE != 0) ? (di >>> 1) : di);
    end

endmodule

// File: rtl/fft_iter_stream.sv
// Iterative radix-2 DIT FFT/IFFT, one butterfly per clock, streaming I/O.
// Ports: in_* sample stream (+in_inverse), out_* bin stream, busy in COMPUTE.
module fft_iter_stream
    import fft_pkg::*;
#(
    parameter int SIZE     = DEF_SIZE,
    parameter int IN_BITS  = 16,
    parameter int OUT_BITS = 24,
    parameter int TW_BITS  = 16,
    parameter int SCALE    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_re,
    input  logic [IN_BITS-1:0]  in_im,
    input  logic                in_inverse,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_re,
    output logic [OUT_BITS-1:0] out_im,
    output logic                out_last,
    output logic                busy
);

    localparam int L  = $clog2(SIZE);
    localparam int HB = L - 1;

    typedef logic signed [OUT_BITS-1:0] smp_t;

    state_t        state_q, state_d;
    logic [L-1:0]  in_cnt_q, in_cnt_d;
    logic [L-1:0]  out_cnt_q, out_cnt_d;
    logic [3:0]    stage_q, stage_d;
    logic [HB-1:0] bfly_q, bfly_d;
    logic          mode_q, mode_d;
    logic          settle_q, settle_d;
    logic          ov_q, ov_d;
    logic          ol_q, ol_d;
    smp_t          ore_q, ore_d;
    smp_t          oim_q, oim_d;

    smp_t mem_re [SIZE];
    smp_t mem_im [SIZE];

    logic signed [TW_BITS-1:0] rom_cos [SIZE/2];
    logic signed [TW_BITS-1:0] rom_sin [SIZE/2];

    for (genvar g = 0; g < SIZE / 2; g++) begin : g_rom
        assign rom_cos[g] = TW_BITS'(twiddle_cos(g, SIZE, TW_BITS));
        assign rom_sin[g] = TW_BITS'(twiddle_sin(g, SIZE, TW_BITS));
    end

    logic [L-1:0]  half, p_addr, q_addr, wa;
    logic [HB-1:0] mask, jj, k_idx;
    logic          ld_we, bf_we;

    logic signed [TW_BITS-1:0] w_re, w_im;
    smp_t x_re, x_im, y_re, y_im;

    always_comb begin
        half   = L'(1) << stage_q;
        mask   = HB'(half - L'(1));
        jj     = bfly_q & mask;
        p_addr = ((L'(bfly_q) >> stage_q) << (stage_q + 4'd1)) | L'(jj);
        q_addr = p_addr | half;
        k_idx  = jj << (4'(L - 1) - stage_q);
        wa     = L'(bitrev(int'(in_cnt_q), L));
        w_re   = rom_cos[k_idx];
        // Forward uses exp(-j), inverse the conjugate.
        w_im   = mode_q ? rom_sin[k_idx] : -rom_sin[k_idx];
    end

    fft_butterfly #(
        .OUT_BITS (OUT_BITS),
        .TW_BITS  (TW_BITS),
        .SCALE    (SCALE)
    ) u_bfly (
        .a_re_i (mem_re[p_addr]),
        .a_im_i (mem_im[p_addr]),
        .b_re_i (mem_re[q_addr]),
        .b_im_i (mem_im[q_addr]),
        .w_re_i (w_re),
        .w_im_i (w_im),
        .x_re_o (x_re),
        .x_im_o (x_im),
        .y_re_o (y_re),
        .y_im_o (y_im)
    );

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        stage_d   = stage_q;
        bfly_d    = bfly_q;
        mode_d    = mode_q;
        settle_d  = settle_q;
        ov_d      = ov_q;
        ol_d      = ol_q;
        ore_d     = ore_q;
        oim_d     = oim_q;
        ld_we     = 1'b0;
        bf_we     = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (in_valid) begin
                    ld_we    = 1'b1;
                    in_cnt_d = in_cnt_q + L'(1);
                    if (in_cnt_q == '0) mode_d = in_inverse;
                    if (in_cnt_q == L'(SIZE - 1)) begin
                        state_d = COMPUTE;
                        stage_d = '0;
                        bfly_d  = '0;
                    end
                end
            end
            COMPUTE: begin
                bf_we  = 1'b1;
                bfly_d = bfly_q + HB'(1);
                if (bfly_q == '1) begin
                    stage_d = stage_q + 4'd1;
                    if (stage_q == 4'(L - 1)) begin
                        state_d   = UNLOAD;
                        settle_d  = 1'b1;
                        out_cnt_d = '0;
                    end
                end
            end
            UNLOAD: begin
                // One idle cycle fixes the input-to-output latency.
                if (settle_q) begin
                    settle_d = 1'b0;
                end else if (ov_q && ol_q && out_ready) begin
                    ov_d     = 1'b0;
                    ol_d     = 1'b0;
                    in_cnt_d = '0;
                    state_d  = LOAD;
                end else if (!ov_q || out_ready) begin
                    ov_d      = 1'b1;
                    ol_d      = (out_cnt_q == L'(SIZE - 1));
                    ore_d     = mem_re[out_cnt_q];
                    oim_d     = mem_im[out_cnt_q];
                    out_cnt_d = out_cnt_q + L'(1);
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            stage_q   <= '0;
            bfly_q    <= '0;
            mode_q    <= 1'b0;
            settle_q  <= 1'b0;
            ov_q      <= 1'b0;
            ol_q      <= 1'b0;
            ore_q     <= '0;
            oim_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            stage_q   <= stage_d;
            bfly_q    <= bfly_d;
            mode_q    <= mode_d;
            settle_q  <= settle_d;
            ov_q      <= ov_d;
            ol_q      <= ol_d;
            ore_q     <= ore_d;
            oim_q     <= oim_d;
        end
    end

    // Sample memory is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_re[wa] <= OUT_BITS'($signed(in_re));
            mem_im[wa] <= OUT_BITS'($signed(in_im));
        end
        if (bf_we) begin
            mem_re[p_addr] <= x_re;
            mem_im[p_addr] <= x_im;
            mem_re[q_addr] <= y_re;
            mem_im[q_addr] <= y_im;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q == COMPUTE);
    assign out_valid = ov_q;
    assign out_last  = ol_q;
    assign out_re    = ore_q;
    assign out_im    = oim_q;

endmodule

// File: tb/tb_fft_iter_stream.sv
// Self-checking bench for fft_iter_stream against a floating-point DFT.
// Two instances: SCALE=0 (sel=0) and SCALE=1 (sel=1).
module tb_fft_iter_stream;

    localparam int  N   = 8;
    localparam int  IB  = 16;
    localparam int  OB  = 24;
    localparam int  LAT = 3 * N / 2 + 2;
    localparam real PI  = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n;
    logic iv, oreq, sel, in_inv;
    logic [IB-1:0] in_re, in_im;

    logic in_valid0, in_valid1, out_ready0, out_ready1;
    logic in_ready0, in_ready1, out_valid0, out_valid1;
    logic out_last0, out_last1, busy0, busy1;
    logic [OB-1:0] out_re0, out_im0, out_re1, out_im1;

    logic irdy, ov, ol, bsy;
    logic [OB-1:0] ore, oim;

    int checks = 0;
    int errors = 0;

    int     tx_re [N], tx_im [N];
    int     rx_re [N], rx_im [N];
    int     og_re [N], og_im [N];
    longint ex_re [N], ex_im [N];

    always #5 clk = ~clk;

    assign in_valid0  = iv & ~sel;
    assign in_valid1  = iv & sel;
    assign out_ready0 = sel ? 1'b1 : oreq;
    assign out_ready1 = sel ? oreq : 1'b1;
    assign irdy = sel ? in_ready1  : in_ready0;
    assign ov   = sel ? out_valid1 : out_valid0;
    assign ol   = sel ? out_last1  : out_last0;
    assign bsy  = sel ? busy1      : busy0;
    assign ore  = sel ? out_re1    : out_re0;
    assign oim  = sel ? out_im1    : out_im0;

    fft_iter_stream #(.SIZE(N), .IN_BITS(IB), .OUT_BITS(OB),
                      .TW_BITS(16), .SCALE(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid0),
        .in_ready   (in_ready0),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_inverse (in_inv),
        .out_valid  (out_valid0),
        .out_ready  (out_ready0),
        .out_re     (out_re0),
        .out_im     (out_im0),
        .out_last   (out_last0),
        .busy       (busy0)
    );

    fft_iter_stream #(.SIZE(N), .IN_BITS(IB), .OUT_BITS(OB),
                      .TW_BITS(16), .SCALE(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_inverse (in_inv),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .out_re     (out_re1),
        .out_im     (out_im1),
        .out_last   (out_last1),
        .busy       (busy1)
    );

    task automatic chk(input string tag, input longint obs,
                       input longint exp, input int tol);
        longint d;
        d = obs - exp;
        if (d < 0) d = -d;
        checks++;
        assert ((d <= tol) === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d",
                   tag, obs, exp, tol);
        end
    endtask

    // Reference: direct DFT, optionally inverse and divided by N.
    task automatic model(input bit inv, input bit scl);
        for (int k = 0; k < N; k++) begin
            real ar, ai, a, c, s;
            ar = 0.0;
            ai = 0.0;
            for (int n = 0; n < N; n++) begin
                a  = 2.0 * PI * real'(k * n) / real'(N);
                c  = $cos(a);
                s  = inv ? $sin(a) : -$sin(a);
                ar = ar + real'(tx_re[n]) * c - real'(tx_im[n]) * s;
                ai = ai + real'(tx_re[n]) * s + real'(tx_im[n]) * c;
            end
            if (scl) begin
                ar = ar / real'(N);
                ai = ai / real'(N);
            end
            ex_re[k] = longint'(ar);
            ex_im[k] = longint'(ai);
        end
    endtask

    task automatic send(input bit inv, input bit gaps);
        for (int n = 0; n < N; n++) begin
            if (gaps) begin
                iv = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            in_re  = IB'(tx_re[n]);
            in_im  = IB'(tx_im[n]);
            in_inv = inv;
            iv     = 1'b1;
            @(negedge clk);
        end
        iv = 1'b0;
    endtask

    task automatic wait_first();
        int lat;
        bit low;
        lat = 0;
        low = 1'b1;
        chk("busy_after_load", longint'(bsy), 1, 0);
        while (!ov && lat < 100) begin
            if (irdy) low = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, LAT, 0);
        chk("in_ready_low", longint'(low), 1, 0);
    endtask

    task automatic recv(input bit stall);
        int got, hold, cyc;
        bit stab, lastok;
        logic [OB-1:0] hre, him;
        got = 0; hold = 0; cyc = 0;
        stab = 1'b1; lastok = 1'b1;
        hre = '0; him = '0;
        oreq = 1'b1;
        while (got < N && cyc < 300) begin
            if (ov) begin
                if (stall && got == 3 && hold < 5) begin
                    if (hold == 0) begin
                        hre = ore;
                        him = oim;
                    end else if (ore !== hre || oim !== him) begin
                        stab = 1'b0;
                    end
                    oreq = 1'b0;
                    hold++;
                end else begin
                    if (stall && got == 3 && (ore !== hre || oim !== him))
                        stab = 1'b0;
                    oreq = 1'b1;
                    rx_re[got] = int'($signed(ore));
                    rx_im[got] = int'($signed(oim));
                    if (ol !== (got == N - 1)) lastok = 1'b0;
                    got++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        oreq = 1'b1;
        chk("bins_received", got, N, 0);
        chk("out_last", longint'(lastok), 1, 0);
        if (stall) begin
            chk("stall_stable", longint'(stab), 1, 0);
            chk("stall_cycles", hold, 5, 0);
        end
        chk("back_to_load", longint'(irdy), 1, 0);
        chk("out_valid_drop", longint'(ov), 0, 0);
    endtask

    task automatic run(input bit s, input bit inv,
                       input bit gaps, input bit stall);
        sel = s;
        send(inv, gaps);
        wait_first();
        recv(stall);
    endtask

    task automatic cmp(input string tag, input int tol);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_re%0d", tag, k), rx_re[k], ex_re[k], tol);
            chk($sformatf("%s_im%0d", tag, k), rx_im[k], ex_im[k], tol);
        end
    endtask

    task automatic set_const(input int v0, input int v);
        for (int n = 0; n < N; n++) begin
            tx_re[n] = (n == 0) ? v0 : v;
            tx_im[n] = 0;
        end
    endtask

    task automatic set_rand();
        for (int n = 0; n < N; n++) begin
            tx_re[n] = int'($urandom_range(0, 2000)) - 1000;
            tx_im[n] = int'($urandom_range(0, 2000)) - 1000;
        end
    endtask

    initial begin
        rst_n = 1'b0; iv = 1'b0; oreq = 1'b1; sel = 1'b0;
        in_inv = 1'b0; in_re = '0; in_im = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(irdy), 1, 0);
        chk("rst_out_valid", longint'(ov), 0, 0);
        chk("rst_out_last", longint'(ol), 0, 0);
        chk("rst_busy", longint'(bsy), 0, 0);
        chk("rst_out_re", longint'(ore), 0, 0);
        chk("rst_out_im", longint'(oim), 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_const(1000, 0);
        run(0, 0, 0, 0);
        model(0, 0);
        cmp("impulse", 0);

        set_const(100, 100);
        run(0, 0, 0, 0);
        model(0, 0);
        cmp("dc", 0);

        set_const(100, 100);
        run(1, 0, 0, 0);
        model(0, 1);
        cmp("dc_scaled", 0);

        for (int n = 0; n < N; n++) begin
            tx_re[n] = int'($cos(2.0 * PI * real'(n) / real'(N)) * 16384.0);
            tx_im[n] = 0;
        end
        run(0, 0, 0, 0);
        model(0, 0);
        cmp("tone", 4);

        set_rand();
        og_re = tx_re;
        og_im = tx_im;
        run(0, 0, 0, 0);
        model(0, 0);
        cmp("rand_fft", 4);
        tx_re = rx_re;
        tx_im = rx_im;
        run(1, 1, 0, 0);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("trip_re%0d", k), rx_re[k], og_re[k], 3);
            chk($sformatf("trip_im%0d", k), rx_im[k], og_im[k], 3);
        end

        set_const(100, 100);
        run(0, 0, 1, 0);
        model(0, 0);
        cmp("dc_gaps", 0);

        set_rand();
        run(0, 0, 1, 1);
        model(0, 0);
        cmp("rand_stall", 4);

        sel = 1'b0;
        set_const(500, 0);
        send(0, 0);
        repeat (5) @(negedge clk);
        chk("mid_busy", longint'(bsy), 1, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", longint'(irdy), 1, 0);
        chk("mid_rst_valid", longint'(ov), 0, 0);
        @(negedge clk);
        chk("mid_rst_ready2", longint'(irdy), 1, 0);
        chk("mid_rst_busy", longint'(bsy), 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        set_const(1000, 0);
        run(0, 0, 0, 0);
        model(0, 0);
        cmp("post_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
